// File: rtl/hazard_unit.sv
// Pipeline hazard control: memory-wait freeze, branch flush, load-use stall.
// Optional perf counters under `HAZARD_PERF_CNT_EN`.
module hazard_unit #(
  parameter int REG_SIZE    = 5,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_SIZE-1:0] id_rs1,
  input  logic [REG_SIZE-1:0] id_rs2,
  input  logic                id_uses_rs1,
  input  logic                id_uses_rs2,
  input  logic [REG_SIZE-1:0] ex_rd,
  input  logic                ex_memRead,
  input  logic                branch_taken,
  input  logic                dmem_req,
  input  logic                dmem_ready,
  output logic                pc_en,
  output logic                ifid_en,
  output logic                idex_en,
  output logic                exmem_en,
  output logic                ifid_flush,
  output logic                idex_flush,
  output logic                memwb_flush,
  output logic                mem_timeout_err,
  output logic [31:0]         stall_cycles,
  output logic [31:0]         flush_count
);

  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] MEM_WAIT = 1'b1;
  localparam logic [7:0] TMO      = 8'(MEM_TIMEOUT);

  logic [0:0] state_q, state_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic       err_q, err_d;
  logic       freeze, load_use, br, lu;

  assign freeze = ((state_q == RUN) && dmem_req && !dmem_ready)
               || ((state_q == MEM_WAIT) && !dmem_ready);

  assign load_use = ex_memRead && (ex_rd != '0)
                 && ((id_uses_rs1 && (ex_rd == id_rs1))
                  || (id_uses_rs2 && (ex_rd == id_rs2)));

  // Mutually exclusive request flags encode the priority order
  assign br = branch_taken && !freeze;
  assign lu = load_use && !freeze && !branch_taken;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    err_d   = err_q;
    if (state_q == RUN) begin
      if (dmem_req && !dmem_ready) begin
        state_d = MEM_WAIT;
        wcnt_d  = '0;
      end
    end else begin
      if (wcnt_q >= TMO) err_d = 1'b1;
      if (dmem_ready) begin
        state_d = RUN;
      end else if (wcnt_q != 8'hFF) begin
        wcnt_d = wcnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
    end
  end

  assign mem_timeout_err = err_q;

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    unique case (1'b1)
      freeze: begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_flush = 1'b1;
      end
      br: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end
      lu: begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_q, flush_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_en)     stall_q <= stall_q + 32'd1;
      if (ifid_flush) flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit (MEM_TIMEOUT=4).
// Directed vectors push expectations; a negedge monitor pops and compares.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       id_uses_rs1 = 0, id_uses_rs2 = 0;
  logic       ex_memRead = 0, branch_taken = 0;
  logic       dmem_req = 0, dmem_ready = 0;
  logic       pc_en, ifid_en, idex_en, exmem_en;
  logic       ifid_flush, idex_flush, memwb_flush;
  logic       mem_timeout_err;
  logic [31:0] stall_cycles, flush_count;

  always #5 clk = ~clk;

  hazard_unit #(.REG_SIZE(5), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_memRead(ex_memRead),
    .branch_taken(branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en),
    .idex_en(idex_en), .exmem_en(exmem_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .memwb_flush(memwb_flush),
    .mem_timeout_err(mem_timeout_err),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  // {pc_en,ifid_en,idex_en,exmem_en,ifid_flush,idex_flush,memwb_flush}
  localparam logic [6:0] N  = 7'b1111000;
  localparam logic [6:0] LU = 7'b0011010;
  localparam logic [6:0] BR = 7'b1111110;
  localparam logic [6:0] FZ = 7'b0000001;

  typedef struct packed {
    int          id;
    logic [6:0]  ctl;
    logic        err;
    logic [31:0] st;
    logic [31:0] fl;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int vec = 0;
  logic [31:0] ms = 0, mf = 0;

  task automatic cyc(
    input logic r,
    input logic [4:0] rs1, input logic [4:0] rs2,
    input logic u1, input logic u2,
    input logic [4:0] erd, input logic mr,
    input logic br, input logic rq, input logic rd,
    input logic [6:0] c, input logic e);
    exp_t x;
    @(posedge clk);
    #1;
    rst = r;
    id_rs1 = rs1; id_rs2 = rs2;
    id_uses_rs1 = u1; id_uses_rs2 = u2;
    ex_rd = erd; ex_memRead = mr;
    branch_taken = br;
    dmem_req = rq; dmem_ready = rd;
    if (r) begin
      ms = 0;
      mf = 0;
    end
    x.id = vec;
    x.ctl = c;
    x.err = e;
`ifdef HAZARD_PERF_CNT_EN
    x.st = ms;
    x.fl = mf;
`else
    x.st = 0;
    x.fl = 0;
`endif
    q.push_back(x);
    vec++;
    if (!r) begin
      if (!c[6]) ms = ms + 1;
      if (c[2]) mf = mf + 1;
    end
  endtask

  initial begin : monitor
    exp_t x;
    logic [6:0] got;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        x = q.pop_front();
        got = {pc_en, ifid_en, idex_en, exmem_en,
               ifid_flush, idex_flush, memwb_flush};
        checks++;
        if (got !== x.ctl) begin
          failures++;
          $display("FAIL ctl v%0d got=%b exp=%b", x.id, got, x.ctl);
        end
        checks++;
        if (mem_timeout_err !== x.err) begin
          failures++;
          $display("FAIL err v%0d got=%b exp=%b",
                   x.id, mem_timeout_err, x.err);
        end
        checks++;
        if (stall_cycles !== x.st) begin
          failures++;
          $display("FAIL stall v%0d got=%0d exp=%0d",
                   x.id, stall_cycles, x.st);
        end
        checks++;
        if (flush_count !== x.fl) begin
          failures++;
          $display("FAIL flush v%0d got=%0d exp=%0d",
                   x.id, flush_count, x.fl);
        end
      end
    end
  end

  initial begin : stim
    //  rst rs1 rs2 u1 u2 erd mr br rq rd  exp err
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, N, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, N, 0);
    // load-use on rs2, then self-clear
    cyc(0, 0, 5, 0, 1, 5, 1, 0, 0, 0, LU, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, N, 0);
    // branch overrides load-use
    cyc(0, 0, 5, 0, 1, 5, 1, 1, 0, 0, BR, 0);
    cyc(0, 7, 0, 1, 0, 7, 1, 0, 0, 0, LU, 0);
    cyc(0, 7, 0, 0, 0, 7, 1, 0, 0, 0, N, 0);
    cyc(0, 7, 0, 1, 0, 7, 0, 0, 0, 0, N, 0);
    // x0 never hazards
    cyc(0, 0, 0, 1, 1, 0, 1, 0, 0, 0, N, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, BR, 0);
    // three-cycle memory wait, branch/load-use ignored
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FZ, 0);
    cyc(0, 3, 0, 1, 0, 3, 1, 1, 1, 0, FZ, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FZ, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, N, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, N, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, N, 0);
    // timeout: entry + wait cycles, err one cycle after cnt==4
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FZ, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FZ, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FZ, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FZ, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FZ, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FZ, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FZ, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, FZ, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, N, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, BR, 1);
    // reset mid-wait abandons it
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FZ, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, FZ, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, N, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, N, 0);
    cyc(0, 0, 9, 0, 1, 9, 1, 0, 0, 0, LU, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, N, 0);
    repeat (3) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain left=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
